decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (32 or 64 only).
REQ-002 SHALL have parameter SKID, default 1, where 1 means a 2-entry skid buffer with registered in_ready and 0 means a 1-entry register with combinational in_ready.
REQ-003 SHALL have port clk  input  1  sole clock, all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  discard all buffered instructions.
REQ-006 SHALL have ports in_valid/in_ready  input/output  1/1  upstream handshake.
REQ-007 SHALL have ports in_inst/in_pc  input  32/XLEN  instruction word and its PC.
REQ-008 SHALL have ports out_valid/out_ready  output/input  1/1  downstream handshake.
REQ-009 SHALL have outputs opcode 7, rd 5, rs1 5, rs2 5, funct3 3, funct7 7, bit20 1, bit30 1, as instruction bit-fields.
REQ-010 SHALL have outputs imm XLEN, out_pc XLEN, fmt 3 (format code), illegal 1.

Function
REQ-011 SHALL accept a beat when in_valid && in_ready, and SHALL deliver it when out_valid && out_ready.
REQ-012 SHALL have latency 1: a beat accepted at edge N into an empty stage appears on the outputs after edge N.
REQ-013 SHALL decode in the input path and register the decoded fields; outputs are driven from storage only.
REQ-014 SHALL deliver beats in order, without loss or duplication.
REQ-015 SHALL, with SKID=1, drive in_ready = (occupancy < 2) from a register and take a simultaneous accept and deliver at occupancy 2 as illegal-for-upstream (in_ready is already 0).
REQ-016 SHALL, with SKID=1 and occupancy 1, allow a simultaneous accept and deliver, leaving occupancy 1.
REQ-017 SHALL, with SKID=0, drive in_ready = !out_valid || out_ready.
REQ-018 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-019 SHALL set fmt by opcode: OP=R; STORE=S; BRANCH=B; LUI/AUIPC=U; JAL=J; all others=I.
REQ-020 SHALL form imm per format, sign-extended from inst[31] to XLEN; the U format places inst[31:12] at bits 31:12 and then sign-extends.
REQ-021 SHALL force rs1=0 for U and J formats, and rs2=0 for I, U and J formats.
REQ-022 SHALL set illegal=1 when inst[1:0]!=2'b11, or the opcode is not one of OP_IMM, LUI, AUIPC, OP, JAL, JALR, BRANCH, LOAD, STORE, MISC_MEM, SYSTEM; the beat is still delivered.
REQ-023 SHALL, on flush, empty the stage at that edge (out_valid=0 next cycle) and ignore any beat accepted in the same cycle.
REQ-024 SHALL give flush priority over simultaneous accept and deliver.

Reset
REQ-025 SHALL, while reset is high, force occupancy 0, out_valid=0, in_ready=1 (SKID=1) and all data outputs to 0, asynchronously.
REQ-026 SHALL discard any buffered beats if reset asserts mid-operation and, after release, SHALL resume accepting on the first clk edge.

Structure
REQ-027 SHALL take opcode constants, the fmt codes (R=0, I=1, S=2, B=3, U=4, J=5) and the legal-opcode function from shared package decode_pkg.
REQ-028 SHALL instantiate one combinational sub-module decode_imm (XLEN param; inst in, fmt and imm out).

Verification
REQ-029 SHALL cover: XLEN=32, in_inst=0xFFF00093, out_ready=1 -> next cycle out_valid=1, fmt=I, rd=1, rs1=0, imm=0xFFFFFFFF, illegal=0.
REQ-030 SHALL cover: XLEN=64, in_inst=0x800000B7 (LUI) -> imm=0xFFFFFFFF80000000, fmt=U, rs1=0, rs2=0.
REQ-031 SHALL cover: SKID=1, out_ready=0, 3 consecutive in_valid beats -> 2 accepted, in_ready=0 from the cycle after the 2nd; raising out_ready delivers them in order.
REQ-032 SHALL cover: in_inst=0x00000000 -> delivered with illegal=1; 0xFE000EE3 (BRANCH) -> fmt=B, imm=0xFFFFFFFC (XLEN=32).
REQ-033 SHALL cover: occupancy 2 plus flush and in_valid in the same cycle -> next cycle out_valid=0, occupancy 0, the flushed-cycle beat never appears.
REQ-034 SHALL cover: reset asserted between clk edges at occupancy 1 -> out_valid=0 immediately; after release, a new beat is delivered with latency 1.

Source files
------------

// File: rtl/decode_pkg.sv
// ----------------------------------------------------------------------------
// decode_pkg : RV opcode constants, format codes and decode helper functions
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package decode_pkg;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // Width-independent part of one decoded beat; imm and pc are stored beside it.
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       bit20;
    logic       bit30;
    logic [2:0] fmt;
    logic       illegal;
  } decoded_t;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OP_OP_IMM, OP_LUI, OP_AUIPC, OP_OP, OP_JAL, OP_JALR,
      OP_BRANCH, OP_LOAD, OP_STORE, OP_MISC_MEM, OP_SYSTEM: is_legal_opcode = 1'b1;
      default:                                              is_legal_opcode = 1'b0;
    endcase
  endfunction

  function automatic fmt_e fmt_of(input logic [6:0] op);
    case (op)
      OP_OP:            fmt_of = FMT_R;
      OP_STORE:         fmt_of = FMT_S;
      OP_BRANCH:        fmt_of = FMT_B;
      OP_LUI, OP_AUIPC: fmt_of = FMT_U;
      OP_JAL:           fmt_of = FMT_J;
      default:          fmt_of = FMT_I;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_imm.sv
// ----------------------------------------------------------------------------
// decode_imm : combinational format classification and immediate extraction
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module decode_imm
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm
);

  fmt_e               w_fmt;
  logic signed [31:0] w_imm32;

  assign w_fmt = fmt_of(inst[6:0]);
  assign fmt   = w_fmt;

  // Build the 32-bit sign-extended immediate first; widening to XLEN is a signed cast.
  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      FMT_I:   w_imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   w_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   w_imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   w_imm32 = {inst[31:12], 12'b0};
      FMT_J:   w_imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign imm = XLEN'(w_imm32);

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage : valid/ready decode pipeline stage with optional 2-entry skid
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic            bit20,
  output logic            bit30,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [2:0]      w_fmt;
  logic [XLEN-1:0] w_imm;
  decoded_t        w_dec;
  logic            w_acc;
  logic            w_del;
  logic [1:0]      w_count_nxt;

  logic [1:0]      r_count;
  decoded_t        r_dec0;
  decoded_t        r_dec1;
  logic [XLEN-1:0] r_imm0;
  logic [XLEN-1:0] r_imm1;
  logic [XLEN-1:0] r_pc0;
  logic [XLEN-1:0] r_pc1;

  decode_imm #(
    .XLEN (XLEN)
  ) u_decode_imm (
    .inst (in_inst),
    .fmt  (w_fmt),
    .imm  (w_imm)
  );

  always_comb begin
    w_dec         = '0;
    w_dec.opcode  = in_inst[6:0];
    w_dec.rd      = in_inst[11:7];
    w_dec.funct3  = in_inst[14:12];
    w_dec.rs1     = (w_fmt == FMT_U || w_fmt == FMT_J) ? 5'd0 : in_inst[19:15];
    w_dec.rs2     = (w_fmt == FMT_I || w_fmt == FMT_U || w_fmt == FMT_J) ? 5'd0 : in_inst[24:20];
    w_dec.funct7  = in_inst[31:25];
    w_dec.bit20   = in_inst[20];
    w_dec.bit30   = in_inst[30];
    w_dec.fmt     = w_fmt;
    w_dec.illegal = (in_inst[1:0] != 2'b11) || !is_legal_opcode(in_inst[6:0]);
  end

  assign out_valid = (r_count != 2'd0);
  assign w_acc     = in_valid && in_ready;
  assign w_del     = out_valid && out_ready;

  // Flush wins over any accept or deliver happening in the same cycle.
  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = 2'd0;
    end else if (w_acc && !w_del) begin
      w_count_nxt = r_count + 2'd1;
    end else if (!w_acc && w_del) begin
      w_count_nxt = r_count - 2'd1;
    end
  end

  // Entry 0 always feeds the outputs; entry 1 only holds a beat while entry 0 is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 2'd0;
      r_dec0  <= '0;
      r_dec1  <= '0;
      r_imm0  <= '0;
      r_imm1  <= '0;
      r_pc0   <= '0;
      r_pc1   <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (!flush) begin
        if (w_del && r_count == 2'd2) begin
          r_dec0 <= r_dec1;
          r_imm0 <= r_imm1;
          r_pc0  <= r_pc1;
        end else if (w_acc && (r_count == 2'd0 || w_del)) begin
          r_dec0 <= w_dec;
          r_imm0 <= w_imm;
          r_pc0  <= in_pc;
        end else if (w_acc) begin
          r_dec1 <= w_dec;
          r_imm1 <= w_imm;
          r_pc1  <= in_pc;
        end
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic r_in_ready;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_count_nxt < 2'd2);
        end
      end

      assign in_ready = r_in_ready;
    end else begin : g_noskid
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  assign opcode  = r_dec0.opcode;
  assign rd      = r_dec0.rd;
  assign rs1     = r_dec0.rs1;
  assign rs2     = r_dec0.rs2;
  assign funct3  = r_dec0.funct3;
  assign funct7  = r_dec0.funct7;
  assign bit20   = r_dec0.bit20;
  assign bit30   = r_dec0.bit30;
  assign fmt     = r_dec0.fmt;
  assign illegal = r_dec0.illegal;
  assign imm     = r_imm0;
  assign out_pc  = r_pc0;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_stage : scoreboard bench, XLEN=32/SKID=1 and XLEN=64/SKID=0 instances
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_decode_stage;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        bit20;
    logic        bit30;
    logic [2:0]  fmt;
    logic        illegal;
    logic [63:0] imm;
    logic [63:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  logic        iv32 = 1'b0, ordy32 = 1'b0, ir32, ov32;
  logic [31:0] inst32 = '0, pc32 = '0;
  logic [6:0]  op32, f7_32;
  logic [4:0]  rd32, rs1_32, rs2_32;
  logic [2:0]  f3_32, fmt32;
  logic        b20_32, b30_32, ill32;
  logic [31:0] imm32, opc32;

  logic        iv64 = 1'b0, ordy64 = 1'b0, ir64, ov64;
  logic [31:0] inst64 = '0;
  logic [63:0] pc64 = '0;
  logic [6:0]  op64, f7_64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  f3_64, fmt64;
  logic        b20_64, b30_64, ill64;
  logic [63:0] imm64, opc64;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .SKID(1)) u_dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(iv32), .in_ready(ir32), .in_inst(inst32), .in_pc(pc32),
    .out_valid(ov32), .out_ready(ordy32),
    .opcode(op32), .rd(rd32), .rs1(rs1_32), .rs2(rs2_32), .funct3(f3_32), .funct7(f7_32),
    .bit20(b20_32), .bit30(b30_32), .imm(imm32), .out_pc(opc32), .fmt(fmt32), .illegal(ill32)
  );

  decode_stage #(.XLEN(64), .SKID(0)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(iv64), .in_ready(ir64), .in_inst(inst64), .in_pc(pc64),
    .out_valid(ov64), .out_ready(ordy64),
    .opcode(op64), .rd(rd64), .rs1(rs1_64), .rs2(rs2_64), .funct3(f3_64), .funct7(f7_64),
    .bit20(b20_64), .bit30(b30_64), .imm(imm64), .out_pc(opc64), .fmt(fmt64), .illegal(ill64)
  );

  // Reference decode: immediates from signed arithmetic on the whole word.
  function automatic exp_t model(input logic [31:0] inst, input logic [63:0] pc, input bit x64);
    exp_t   e;
    longint s, hi, v;
    int     f;
    logic [6:0] op;
    op = inst[6:0];
    s  = longint'($signed(inst));
    case (op)
      7'h33:        f = 0;
      7'h23:        f = 2;
      7'h63:        f = 3;
      7'h37, 7'h17: f = 4;
      7'h6F:        f = 5;
      default:      f = 1;
    endcase
    v = 0;
    case (f)
      1: v = s >>> 20;
      2: begin hi = s >>> 25; v = hi * 32 + longint'(inst[11:7]); end
      3: begin hi = s >>> 31; v = hi * 4096 + longint'(inst[7]) * 2048
                                + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2; end
      4: begin hi = s >>> 12; v = hi * 4096; end
      5: begin hi = s >>> 31; v = hi * 1048576 + longint'(inst[19:12]) * 4096
                                + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2; end
      default: v = 0;
    endcase
    e.opcode  = op;
    e.rd      = inst[11:7];
    e.rs1     = (f == 4 || f == 5) ? 5'd0 : inst[19:15];
    e.rs2     = (f == 1 || f == 4 || f == 5) ? 5'd0 : inst[24:20];
    e.funct3  = inst[14:12];
    e.funct7  = inst[31:25];
    e.bit20   = inst[20];
    e.bit30   = inst[30];
    e.fmt     = 3'(f);
    e.illegal = (inst[1:0] != 2'b11) ||
                !(op inside {7'h13, 7'h37, 7'h17, 7'h33, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h0F, 7'h73});
    e.imm     = x64 ? 64'(v) : {32'b0, 32'(v)};
    e.pc      = x64 ? pc : {32'b0, pc[31:0]};
    return e;
  endfunction

  function automatic exp_t act32();
    exp_t a;
    a = '{op32, rd32, rs1_32, rs2_32, f3_32, f7_32, b20_32, b30_32, fmt32, ill32,
          {32'b0, imm32}, {32'b0, opc32}};
    return a;
  endfunction

  function automatic exp_t act64();
    exp_t a;
    a = '{op64, rd64, rs1_64, rs2_64, f3_64, f7_64, b20_64, b30_64, fmt64, ill64, imm64, opc64};
    return a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue side: every accepted beat pushes its expected decode.
  always @(negedge clk) begin
    if (!reset && !flush) begin
      if (iv32 && ir32) q32.push_back(model(inst32, {32'b0, pc32}, 1'b0));
      if (iv64 && ir64) q64.push_back(model(inst64, pc64, 1'b1));
    end
  end

  exp_t prev32;
  bit   stall32 = 1'b0;

  always @(negedge clk) begin
    exp_t a, e;
    a = act32();
    if (reset) begin
      q32.delete();
      stall32 = 1'b0;
    end else begin
      if (stall32) begin
        n_vec++;
        if (!ov32 || a !== prev32) begin
          n_bad++;
          $display("FAIL hold32: got v=%0b %h expected v=1 %h", ov32, a, prev32);
        end
      end
      if (flush) begin
        q32.delete();
      end else if (ov32 && ordy32) begin
        n_vec++;
        if (q32.size() == 0) begin
          n_bad++;
          $display("FAIL extra32: got %h expected nothing", a);
        end else begin
          e = q32.pop_front();
          if (a !== e) begin
            n_bad++;
            $display("FAIL item32: got %h expected %h", a, e);
          end
        end
      end
      stall32 = ov32 && !ordy32 && !flush;
      prev32  = a;
    end
  end

  always @(negedge clk) begin
    exp_t a, e;
    a = act64();
    if (reset) begin
      q64.delete();
    end else begin
      chk("inready64", {63'b0, ir64}, {63'b0, (!ov64 || ordy64)});
      if (flush) begin
        q64.delete();
      end else if (ov64 && ordy64) begin
        n_vec++;
        if (q64.size() == 0) begin
          n_bad++;
          $display("FAIL extra64: got %h expected nothing", a);
        end else begin
          e = q64.pop_front();
          if (a !== e) begin
            n_bad++;
            $display("FAIL item64: got %h expected %h", a, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                              7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    logic [31:0] w;
    w = $urandom();
    if ($urandom_range(0, 9) < 8) w[6:0] = ops[$urandom_range(0, 10)];
    return w;
  endfunction

  initial begin
    int budget;
    #1 reset = 1'b1;
    #2;
    chk("rst_ov32",  {63'b0, ov32}, 64'd0);
    chk("rst_ir32",  {63'b0, ir32}, 64'd1);
    chk("rst_imm32", {32'b0, imm32}, 64'd0);
    chk("rst_dec32", {32'b0, op32, rd32, rs1_32, rs2_32, fmt32, ill32}, 64'd0);
    chk("rst_ov64",  {63'b0, ov64}, 64'd0);
    chk("rst_imm64", imm64, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // addi x1,x0,-1 on the 32-bit stage and lui with bit31 set on the 64-bit stage
    ordy32 = 1'b1; iv32 = 1'b1; inst32 = 32'hFFF00093; pc32 = 32'h100;
    ordy64 = 1'b1; iv64 = 1'b1; inst64 = 32'h800000B7; pc64 = 64'h8000_0000_0000_0040;
    tick();
    iv32 = 1'b0; iv64 = 1'b0;
    chk("addi_ov",  {63'b0, ov32}, 64'd1);
    chk("addi_fmt", {61'b0, fmt32}, 64'd1);
    chk("addi_rd",  {59'b0, rd32}, 64'd1);
    chk("addi_rs1", {59'b0, rs1_32}, 64'd0);
    chk("addi_imm", {32'b0, imm32}, 64'hFFFF_FFFF);
    chk("addi_ill", {63'b0, ill32}, 64'd0);
    chk("lui_ov",   {63'b0, ov64}, 64'd1);
    chk("lui_imm",  imm64, 64'hFFFF_FFFF_8000_0000);
    chk("lui_fmt",  {61'b0, fmt64}, 64'd4);
    chk("lui_rs",   {54'b0, rs1_64, rs2_64}, 64'd0);
    tick();

    // all-zero word is illegal but still delivered; then a negative branch offset
    iv32 = 1'b1; inst32 = 32'h0000_0000; pc32 = 32'h200;
    tick();
    chk("zero_ill", {63'b0, ill32}, 64'd1);
    chk("zero_ov",  {63'b0, ov32}, 64'd1);
    inst32 = 32'hFE000EE3; pc32 = 32'h204;
    tick();
    iv32 = 1'b0;
    chk("br_fmt", {61'b0, fmt32}, 64'd3);
    chk("br_imm", {32'b0, imm32}, 64'hFFFF_FFFC);
    tick();
    chk("br_drain", {63'b0, ov32}, 64'd0);

    // back-pressure: third beat must wait until the skid buffer drains
    ordy32 = 1'b0; iv32 = 1'b1; inst32 = rand_inst(); pc32 = 32'd1;
    chk("bp_ir_a", {63'b0, ir32}, 64'd1);
    tick();
    inst32 = rand_inst(); pc32 = 32'd2;
    chk("bp_ir_b", {63'b0, ir32}, 64'd1);
    tick();
    inst32 = rand_inst(); pc32 = 32'd3;
    chk("bp_ir_full", {63'b0, ir32}, 64'd0);
    chk("bp_head",    {32'b0, opc32}, 64'd1);
    tick();
    chk("bp_ir_held", {63'b0, ir32}, 64'd0);
    chk("bp_head2",   {32'b0, opc32}, 64'd1);
    ordy32 = 1'b1;
    tick();
    chk("bp_ir_free", {63'b0, ir32}, 64'd1);
    chk("bp_second",  {32'b0, opc32}, 64'd2);
    tick();
    iv32 = 1'b0;
    chk("bp_third", {32'b0, opc32}, 64'd3);
    tick();
    chk("bp_empty", {63'b0, ov32}, 64'd0);

    // flush at full occupancy with a beat offered in the same cycle
    ordy32 = 1'b0; iv32 = 1'b1; inst32 = rand_inst(); pc32 = 32'd10;
    ordy64 = 1'b0; iv64 = 1'b1; inst64 = rand_inst(); pc64 = 64'd20;
    tick();
    inst32 = rand_inst(); pc32 = 32'd11; iv64 = 1'b0;
    tick();
    flush = 1'b1; inst32 = rand_inst(); pc32 = 32'd12;
    iv64 = 1'b1; ordy64 = 1'b1; inst64 = rand_inst(); pc64 = 64'd21;
    tick();
    flush = 1'b0; iv32 = 1'b0; iv64 = 1'b0; ordy32 = 1'b1;
    chk("fl_ov32", {63'b0, ov32}, 64'd0);
    chk("fl_ir32", {63'b0, ir32}, 64'd1);
    chk("fl_ov64", {63'b0, ov64}, 64'd0);
    tick(); tick(); tick();
    chk("fl_still32", {63'b0, ov32}, 64'd0);
    chk("fl_still64", {63'b0, ov64}, 64'd0);

    // asynchronous reset in the middle of a cycle with one beat buffered
    ordy32 = 1'b0; iv32 = 1'b1; inst32 = rand_inst(); pc32 = 32'd30;
    tick();
    iv32 = 1'b0;
    chk("ar_pre", {63'b0, ov32}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_ov",  {63'b0, ov32}, 64'd0);
    chk("ar_ir",  {63'b0, ir32}, 64'd1);
    chk("ar_pc",  {32'b0, opc32}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    iv32 = 1'b1; ordy32 = 1'b1; inst32 = rand_inst(); pc32 = 32'd31;
    tick();
    iv32 = 1'b0;
    chk("ar_new_ov", {63'b0, ov32}, 64'd1);
    chk("ar_new_pc", {32'b0, opc32}, 64'd31);
    tick();

    // randomized traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      iv32   = ($urandom_range(0, 9) < 7);
      ordy32 = ($urandom_range(0, 9) < 6);
      inst32 = rand_inst();
      pc32   = $urandom();
      iv64   = ($urandom_range(0, 9) < 7);
      ordy64 = ($urandom_range(0, 9) < 6);
      inst64 = rand_inst();
      pc64   = {$urandom(), $urandom()};
      flush  = ($urandom_range(0, 49) == 0);
      tick();
    end

    iv32 = 1'b0; iv64 = 1'b0; flush = 1'b0; ordy32 = 1'b1; ordy64 = 1'b1;
    budget = 0;
    while ((q32.size() != 0 || q64.size() != 0) && budget < 20) begin
      tick();
      budget++;
    end
    tick();
    chk("drain32", 64'(q32.size()), 64'd0);
    chk("drain64", 64'(q64.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
